// File: rtl/aes_pkg.sv
// Shared types and widths for the AES pipeline controller and its output buffer.
package aes_pkg;

    localparam int AES_LAT     = 13;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_KEY_W   = 256;

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } aes_state_e;

endpackage

// File: rtl/aes_pipe_fifo.sv
// Circular output buffer for ciphertext blocks; head is visible while not empty.
module aes_pipe_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/aes_pipe_ctrl.sv
// Flow control around a fixed-latency AES core: key sequencing, credit-based
// admission and an output buffer that absorbs consumer backpressure.
module aes_pipe_ctrl
    import aes_pkg::*;
#(
    parameter int LAT   = AES_LAT,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [AES_KEY_W-1:0]   key_in,
    output logic [AES_BLOCK_W-1:0] core_datain,
    output logic [AES_KEY_W-1:0]   core_key,
    input  logic [AES_BLOCK_W-1:0] core_dataout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(LAT + 1);

    if (DEPTH < LAT) begin : g_depth_check
        $error("aes_pipe_ctrl: DEPTH must be at least LAT");
    end

    aes_state_e       state;
    aes_state_e       state_next;
    logic [LAT-1:0]   vsr;
    logic [FW-1:0]    in_flight;
    logic [CW-1:0]    count;
    logic [31:0]      occupancy;
    logic             fifo_empty;
    logic             in_fire;
    logic             key_fire;
    logic             pop;

    assign core_datain = in_data;
    assign in_fire     = in_valid && in_ready;
    assign key_fire    = key_valid && key_ready;
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign busy        = (in_flight != '0) || !fifo_empty;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LAT; i++) begin
            in_flight = in_flight + FW'(vsr[i]);
        end
    end

    // Admission counts every block already committed to a buffer slot, so the
    // buffer can never be asked to take more than it holds.
    assign occupancy = 32'(in_flight) + 32'(count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NOKEY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        key_ready  = 1'b0;
        in_ready   = 1'b0;
        case (state)
            NOKEY: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                key_ready = (in_flight == '0);
                in_ready  = !key_valid && (occupancy < 32'(DEPTH));
                if (key_valid && (in_flight != '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                key_ready = (in_flight == '0);
                if (key_valid && key_ready) begin
                    state_next = RUN;
                end
            end
            default: state_next = NOKEY;
        endcase
    end

    // Key swaps only happen with the core empty, so old blocks finish on the old key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_key <= '0;
            vsr      <= '0;
        end else begin
            if (key_fire) begin
                core_key <= key_in;
            end
            vsr <= (vsr << 1) | LAT'(in_fire);
        end
    end

    aes_pipe_fifo #(
        .WIDTH (AES_BLOCK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vsr[LAT-1]),
        .push_data (core_dataout),
        .pop       (pop),
        .head      (out_data),
        .count     (count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Scoreboard bench for aes_pipe_ctrl with a fixed-latency stand-in for the AES core.
module tb_aes_pipe_ctrl;

    localparam int LAT   = 13;
    localparam int DEPTH = 16;

    localparam logic [255:0] KAT_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [255:0] key_in = '0;
    logic [127:0] core_datain;
    logic [255:0] core_key;
    logic [127:0] core_dataout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic [255:0] model_key = '0;
    bit           has_key = 0;
    bit           draining = 0;
    int           outstanding = 0;
    int           max_outstanding = 0;
    int           pop_total = 0;
    int           last_pop_cyc = 0;
    bit           rand_ready = 0;

    logic [127:0] pipe [LAT];

    aes_pipe_ctrl #(
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_in       (key_in),
        .core_datain  (core_datain),
        .core_key     (core_key),
        .core_dataout (core_dataout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: the known-answer pair maps exactly, anything else gets a keyed scramble.
    function automatic logic [127:0] cipherModel(input logic [127:0] d, input logic [255:0] k);
        if (d == KAT_PT && k == KAT_KEY) begin
            return KAT_CT;
        end
        return ({d[62:0], d[127:63]} ^ k[127:0]) + k[255:128];
    endfunction

    always @(posedge clk) begin
        pipe[0] <= cipherModel(core_datain, core_key);
        for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign core_dataout = pipe[LAT-1];

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_assert++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: a block is in flight for LAT cycles after its accept, then sits buffered until popped.
    always @(negedge clk) begin
        if (!rst) begin
            int inflight;
            int buffered;
            while (acc_q.size() > 0 && acc_q[0] < cyc - LAT) begin
                void'(acc_q.pop_front());
            end
            inflight = acc_q.size();
            buffered = outstanding - inflight;
            checkOutput("in_ready", 256'(in_ready),
                        256'(has_key && !draining && !key_valid && (outstanding < DEPTH)));
            checkOutput("key_ready", 256'(key_ready), 256'(!has_key || (inflight == 0)));
            checkOutput("out_valid", 256'(out_valid), 256'(buffered > 0));
            checkOutput("busy", 256'(busy), 256'(outstanding != 0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 256'(out_data), 256'(0));
                end else begin
                    checkOutput("out_data", 256'(out_data), 256'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        outstanding--;
                        pop_total++;
                        last_pop_cyc = cyc;
                    end
                end
            end
            if (key_valid && key_ready) begin
                model_key = key_in;
                has_key   = 1;
                draining  = 0;
            end else if (has_key && key_valid && inflight != 0) begin
                draining = 1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cipherModel(in_data, model_key));
                acc_q.push_back(cyc);
                outstanding++;
                if (outstanding > max_outstanding) max_outstanding = outstanding;
            end
        end
    end

    task automatic applyStimulus(input int n, input bit fixed, input logic [127:0] fixed_data,
                                 output int first_acc, output int last_acc);
        first_acc = -1;
        last_acc  = -1;
        for (int i = 0; i < n; i++) begin
            bit accepted;
            int waited;
            in_data  = fixed ? fixed_data : {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            accepted = 0;
            waited   = 0;
            while (!accepted && waited < 300) begin
                @(negedge clk);
                if (in_ready) begin
                    accepted = 1;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
                waited++;
                @(posedge clk);
                #1;
            end
            if (!accepted) begin
                checkOutput("in_accept_timeout", 256'(0), 256'(1));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic loadKey(input logic [255:0] k, output int waited);
        bit done;
        key_in    = k;
        key_valid = 1'b1;
        waited    = 0;
        done      = 0;
        while (!done && waited < 300) begin
            @(negedge clk);
            if (key_ready) done = 1;
            else waited++;
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        if (!done) checkOutput("key_timeout", 256'(0), 256'(1));
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        while (outstanding != 0 && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        if (outstanding != 0) checkOutput("drain_timeout", 256'(outstanding), 256'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fa, la, w, pops_before, t_out;
        logic [255:0] k2;

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 256'(in_ready), 256'(0));
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_key_ready", 256'(key_ready), 256'(1));
        checkOutput("rst_core_key", core_key, 256'(0));
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] known-answer block");
        out_ready = 1'b1;
        loadKey(KAT_KEY, w);
        checkOutput("nokey_key_wait", 256'(w), 256'(0));
        checkOutput("core_key_loaded", core_key, KAT_KEY);
        applyStimulus(1, 1'b1, KAT_PT, fa, la);
        t_out = -1;
        for (int i = 0; i < 40 && t_out < 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                t_out = cyc;
                checkOutput("kat_data", 256'(out_data), 256'(KAT_CT));
            end
        end
        checkOutput("kat_latency", 256'(t_out - fa), 256'(LAT + 1));
        waitIdle();

        $display("[TB] streaming");
        pops_before = pop_total;
        applyStimulus(100, 1'b0, '0, fa, la);
        checkOutput("stream_in_gapless", 256'(la - fa), 256'(99));
        waitIdle();
        checkOutput("stream_count", 256'(pop_total - pops_before), 256'(100));
        checkOutput("stream_last_out", 256'(last_pop_cyc - fa), 256'(99 + LAT + 1));

        $display("[TB] backpressure");
        max_outstanding = 0;
        pops_before     = pop_total;
        out_ready       = 1'b0;
        fork
            applyStimulus(60, 1'b0, '0, fa, la);
            begin
                repeat (40) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitIdle();
        checkOutput("bp_max_credit", 256'(max_outstanding), 256'(DEPTH));
        checkOutput("bp_count", 256'(pop_total - pops_before), 256'(60));

        $display("[TB] random backpressure");
        rand_ready = 1;
        applyStimulus(80, 1'b0, '0, fa, la);
        waitIdle();
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        $display("[TB] key change while in flight");
        applyStimulus(30, 1'b0, '0, fa, la);
        repeat (8) @(posedge clk);
        #1;
        k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        loadKey(k2, w);
        checkOutput("drain_edges", 256'(w), 256'(5));
        checkOutput("core_key_new", core_key, k2);
        applyStimulus(20, 1'b0, '0, fa, la);
        waitIdle();
        loadKey({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, w);
        checkOutput("idle_key_wait", 256'(w), 256'(0));
        applyStimulus(10, 1'b0, '0, fa, la);
        waitIdle();

        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        applyStimulus(10, 1'b0, '0, fa, la);
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        checkOutput("pre_rst_out_valid", 256'(out_valid), 256'(1));
        checkOutput("pre_rst_outstanding", 256'(outstanding), 256'(10));
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("mid_rst_busy", 256'(busy), 256'(0));
        checkOutput("mid_rst_in_ready", 256'(in_ready), 256'(0));
        checkOutput("mid_rst_key_ready", 256'(key_ready), 256'(1));
        exp_q.delete();
        acc_q.delete();
        outstanding = 0;
        has_key     = 0;
        draining    = 0;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("post_rst_core_key", core_key, 256'(0));
        loadKey({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, w);
        applyStimulus(10, 1'b0, '0, fa, la);
        waitIdle();
        checkOutput("final_queue_empty", 256'(exp_q.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_pipe_ctrl.md
AES_PIPE_CTRL -- requirements
Module: aes_pipe_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 13: aescipher clock-edge latency from datain to dataout.
REQ-002 SHALL have parameter DEPTH, default 16: output buffer entries; a value below LAT SHALL be rejected at elaboration.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  plaintext block offered.
REQ-006 SHALL have port in_ready  output  1  block accepted when in_valid & in_ready.
REQ-007 SHALL have port in_data  input  128  plaintext block.
REQ-008 SHALL have port key_valid  input  1  new 256-bit key offered.
REQ-009 SHALL have port key_ready  output  1  key accepted when key_valid & key_ready.
REQ-010 SHALL have port key_in  input  256  cipher key.
REQ-011 SHALL have port core_datain  output  128  to aescipher datain, equal to in_data.
REQ-012 SHALL have port core_key  output  256  to aescipher key, registered.
REQ-013 SHALL have port core_dataout  input  128  from aescipher dataout.
REQ-014 SHALL have port out_valid  output  1  ciphertext available.
REQ-015 SHALL have port out_ready  input  1  consumer takes block when out_valid & out_ready.
REQ-016 SHALL have port out_data  output  128  ciphertext, head of buffer.
REQ-017 SHALL have port busy  output  1  high when in_flight != 0 or buffer not empty.

Function
REQ-018 SHALL implement states NOKEY, RUN, DRAIN.
REQ-019 NOKEY: in_ready=0; key_ready=1; on key handshake -> RUN.
REQ-020 RUN: key_valid with in_flight!=0 -> DRAIN; key_valid with in_flight==0 -> key handshake, stay RUN.
REQ-021 DRAIN: in_ready=0; key_ready = (in_flight==0); on key handshake -> RUN.
REQ-022 core_key SHALL load key_in on the edge of a key handshake and SHALL be otherwise constant.
REQ-023 in_ready SHALL be state==RUN & !key_valid & (in_flight + count < DEPTH), with count the buffer occupancy before this cycle's pop.
REQ-024 An LAT-bit valid shift register SHALL shift every cycle, inserting 1 on input handshake and 0 otherwise.
REQ-025 in_flight SHALL equal the number of set bits in the shift register, 0..LAT.
REQ-026 When the shift register's last bit is 1, core_dataout SHALL be written to the buffer on that edge.
REQ-027 A block accepted in cycle t SHALL appear on out_data with out_valid in cycle t+LAT+1 when the buffer is otherwise empty.
REQ-028 Output order SHALL equal input order.
REQ-029 The buffer SHALL support push and pop on the same edge with count unchanged.
REQ-030 Credit rule (REQ-023) SHALL make buffer overflow impossible under any out_ready pattern; a push while full is a design error and SHALL be flagged by assertion.
REQ-031 With out_ready held 1 and in_valid held 1 in RUN, throughput SHALL be one block per cycle.
REQ-032 out_data SHALL hold stable while out_valid & !out_ready.

Reset
REQ-033 On rst: state=NOKEY, shift register=0, buffer empty, core_key=0.
REQ-034 During and after rst until the first key: in_ready=0, out_valid=0, busy=0, key_ready=1.
REQ-035 A reset mid-operation SHALL discard all in-flight and buffered blocks and SHALL never emit them.

Structure
REQ-036 Shared package aes_pkg SHALL hold the state enum, the LAT default (13), the block width (128) and the key width (256).
REQ-037 The output buffer SHALL be sub-module aes_pipe_fifo, parameterised by width and DEPTH.
REQ-038 aescipher SHALL be instantiated by the parent, not inside this block.

Verification
REQ-039 Reset, key K=0x000102...1f, single block 0x00112233445566778899aabbccddeeff -> out_data 0x8ea2b7ca516745bfeafc49904b496089 in cycle accept+14.
REQ-040 Streaming: 100 back-to-back blocks with out_ready=1 -> 100 outputs in order, one per cycle, with no in_ready gap.
REQ-041 Backpressure: out_ready=0 for 40 cycles while streaming -> in_ready drops when in_flight+count=16; no loss; order preserved.
REQ-042 Key change at in_flight=5 -> state DRAIN, key_ready rises exactly 5 edges later; the 5 old-key results are correct and later blocks use the new key.
REQ-043 rst asserted with 7 blocks in flight and 3 buffered -> out_valid=0 immediately, no stale output, and NOKEY behaviour resumes.
